// File: rtl/core_pkg.sv
// Shared definitions for the core's hazard and forwarding logic.
package core_pkg;

  localparam int unsigned REG_ADDR_W = 5;

  // E-stage operand mux4 select codes
  localparam logic [1:0] FWD_REG  = 2'b00;
  localparam logic [1:0] FWD_W    = 2'b01;
  localparam logic [1:0] FWD_HELD = 2'b10;

  typedef enum logic [0:0] {
    StRun,
    StMduWait
  } hz_state_e;

endpackage

// File: rtl/fwd_match.sv
// Per-operand dependency check: D source vs E producer (load-use),
// E source vs W producer (forwarding), and the resulting mux select.
module fwd_match #(
  parameter int unsigned REG_ADDR_W = core_pkg::REG_ADDR_W
) (
  input  logic [REG_ADDR_W-1:0] rs_d,
  input  logic [REG_ADDR_W-1:0] rs_e,
  input  logic [REG_ADDR_W-1:0] rd_e,
  input  logic                  regwrite_e,
  input  logic [REG_ADDR_W-1:0] rd_w,
  input  logic                  regwrite_w,
  input  logic                  held_valid,
  output logic                  match_e,
  output logic                  match_w,
  output logic [1:0]            fwd_sel
);
  import core_pkg::*;

  // x0 is hardwired zero, so it never matches a producer
  always_comb begin
    match_e = (rs_d != '0) && regwrite_e && (rs_d == rd_e);
    match_w = (rs_e != '0) && regwrite_w && (rs_e == rd_w);
  end

  // A held operand wins over a live W match: W may hold an unrelated bubble by then
  always_comb begin
    fwd_sel = FWD_REG;
    if (held_valid) begin
      fwd_sel = FWD_HELD;
    end else if (match_w) begin
      fwd_sel = FWD_W;
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Hazard and forwarding controller for the 4-stage F/D/E/W core.
// Generates stall/flush controls, E-stage operand selects, and holds
// W-stage results that would be lost while E is frozen by the MDU.
module hazard_unit #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned REG_ADDR_W = core_pkg::REG_ADDR_W,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] rs1_d,
  input  logic [REG_ADDR_W-1:0] rs2_d,
  input  logic [REG_ADDR_W-1:0] rs1_e,
  input  logic [REG_ADDR_W-1:0] rs2_e,
  input  logic [REG_ADDR_W-1:0] rd_e,
  input  logic [REG_ADDR_W-1:0] rd_w,
  input  logic                  regwrite_e,
  input  logic                  regwrite_w,
  input  logic                  load_e,
  input  logic                  pc_src_e,
  input  logic                  mdu_start_e,
  input  logic                  mdu_done,
  input  logic [DATA_WIDTH-1:0] result_w,
  output logic                  stall_f,
  output logic                  stall_d,
  output logic                  stall_e,
  output logic                  flush_d,
  output logic                  flush_e,
  output logic                  flush_w,
  output logic [1:0]            fwd_a_e,
  output logic [1:0]            fwd_b_e,
  output logic [DATA_WIDTH-1:0] held_a,
  output logic [DATA_WIDTH-1:0] held_b,
  output logic [CNT_WIDTH-1:0]  stall_cnt
);
  import core_pkg::*;

  hz_state_e             state_q, state_d;
  logic                  held_valid_a_q, held_valid_b_q;
  logic [DATA_WIDTH-1:0] held_a_q, held_b_q;
  logic [CNT_WIDTH-1:0]  stall_cnt_q;

  logic       match_e_a, match_e_b;
  logic       match_w_a, match_w_b;
  logic [1:0] sel_a, sel_b;
  logic       load_use;
  logic       cap_a, cap_b;
  logic       clr_held;

  fwd_match #(
    .REG_ADDR_W(REG_ADDR_W)
  ) u_fwd_a (
    .rs_d      (rs1_d),
    .rs_e      (rs1_e),
    .rd_e      (rd_e),
    .regwrite_e(regwrite_e),
    .rd_w      (rd_w),
    .regwrite_w(regwrite_w),
    .held_valid(held_valid_a_q),
    .match_e   (match_e_a),
    .match_w   (match_w_a),
    .fwd_sel   (sel_a)
  );

  fwd_match #(
    .REG_ADDR_W(REG_ADDR_W)
  ) u_fwd_b (
    .rs_d      (rs2_d),
    .rs_e      (rs2_e),
    .rd_e      (rd_e),
    .regwrite_e(regwrite_e),
    .rd_w      (rd_w),
    .regwrite_w(regwrite_w),
    .held_valid(held_valid_b_q),
    .match_e   (match_e_b),
    .match_w   (match_w_b),
    .fwd_sel   (sel_b)
  );

  assign load_use = load_e && (match_e_a || match_e_b);

  // Next-state and Mealy stall/flush/capture controls
  always_comb begin
    state_d  = state_q;
    stall_f  = 1'b0;
    stall_d  = 1'b0;
    stall_e  = 1'b0;
    flush_d  = 1'b0;
    flush_e  = 1'b0;
    flush_w  = 1'b0;
    cap_a    = 1'b0;
    cap_b    = 1'b0;
    clr_held = 1'b0;
    if (rst) begin
      // Bubble every stage while in reset; state is forced by the register
      flush_d = 1'b1;
      flush_e = 1'b1;
      flush_w = 1'b1;
    end else begin
      unique case (state_q)
        StRun: begin
          if (pc_src_e) begin
            // Taken branch kills the younger instructions; no stall needed
            flush_d = 1'b1;
            flush_e = 1'b1;
          end else if (mdu_start_e && !mdu_done) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            flush_w = 1'b1;
            // W leaves this cycle; keep any operand it was forwarding
            cap_a   = match_w_a;
            cap_b   = match_w_b;
            state_d = StMduWait;
          end else if (load_use) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
          end
        end
        StMduWait: begin
          if (mdu_done) begin
            clr_held = 1'b1;
            state_d  = StRun;
          end else begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            flush_w = 1'b1;
          end
        end
        default: state_d = StRun;
      endcase
    end
  end

  // Operand selects, forced to the register path during reset
  always_comb begin
    fwd_a_e = rst ? FWD_REG : sel_a;
    fwd_b_e = rst ? FWD_REG : sel_b;
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StRun;
    end else begin
      state_q <= state_d;
    end
  end

  // Held operand A: captured on MDU entry, invalidated when the op retires
  always_ff @(posedge clk) begin
    if (rst) begin
      held_a_q       <= '0;
      held_valid_a_q <= 1'b0;
    end else if (cap_a) begin
      held_a_q       <= result_w;
      held_valid_a_q <= 1'b1;
    end else if (clr_held) begin
      held_valid_a_q <= 1'b0;
    end
  end

  // Held operand B: same policy as operand A
  always_ff @(posedge clk) begin
    if (rst) begin
      held_b_q       <= '0;
      held_valid_b_q <= 1'b0;
    end else if (cap_b) begin
      held_b_q       <= result_w;
      held_valid_b_q <= 1'b1;
    end else if (clr_held) begin
      held_valid_b_q <= 1'b0;
    end
  end

  // Stall performance counter, wraps naturally
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (stall_f) begin
      stall_cnt_q <= stall_cnt_q + CNT_WIDTH'(1);
    end
  end

  assign held_a    = held_a_q;
  assign held_b    = held_b_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed self-checking bench for hazard_unit.
module tb_hazard_unit;

  logic        clk;
  logic        rst;
  logic [4:0]  rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_w;
  logic        regwrite_e, regwrite_w, load_e, pc_src_e, mdu_start_e, mdu_done;
  logic [31:0] result_w;

  logic        stall_f, stall_d, stall_e, flush_d, flush_e, flush_w;
  logic [1:0]  fwd_a_e, fwd_b_e;
  logic [31:0] held_a, held_b, stall_cnt;

  logic        c4_stall_f, c4_stall_d, c4_stall_e, c4_flush_d, c4_flush_e, c4_flush_w;
  logic [1:0]  c4_fwd_a_e, c4_fwd_b_e;
  logic [31:0] c4_held_a, c4_held_b;
  logic [3:0]  c4_stall_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  hazard_unit u_dut (
    .clk        (clk),
    .rst        (rst),
    .rs1_d      (rs1_d),
    .rs2_d      (rs2_d),
    .rs1_e      (rs1_e),
    .rs2_e      (rs2_e),
    .rd_e       (rd_e),
    .rd_w       (rd_w),
    .regwrite_e (regwrite_e),
    .regwrite_w (regwrite_w),
    .load_e     (load_e),
    .pc_src_e   (pc_src_e),
    .mdu_start_e(mdu_start_e),
    .mdu_done   (mdu_done),
    .result_w   (result_w),
    .stall_f    (stall_f),
    .stall_d    (stall_d),
    .stall_e    (stall_e),
    .flush_d    (flush_d),
    .flush_e    (flush_e),
    .flush_w    (flush_w),
    .fwd_a_e    (fwd_a_e),
    .fwd_b_e    (fwd_b_e),
    .held_a     (held_a),
    .held_b     (held_b),
    .stall_cnt  (stall_cnt)
  );

  // Narrow-counter instance sharing the same stimulus, for the wrap check
  hazard_unit #(
    .CNT_WIDTH(4)
  ) u_dut_c4 (
    .clk        (clk),
    .rst        (rst),
    .rs1_d      (rs1_d),
    .rs2_d      (rs2_d),
    .rs1_e      (rs1_e),
    .rs2_e      (rs2_e),
    .rd_e       (rd_e),
    .rd_w       (rd_w),
    .regwrite_e (regwrite_e),
    .regwrite_w (regwrite_w),
    .load_e     (load_e),
    .pc_src_e   (pc_src_e),
    .mdu_start_e(mdu_start_e),
    .mdu_done   (mdu_done),
    .result_w   (result_w),
    .stall_f    (c4_stall_f),
    .stall_d    (c4_stall_d),
    .stall_e    (c4_stall_e),
    .flush_d    (c4_flush_d),
    .flush_e    (c4_flush_e),
    .flush_w    (c4_flush_w),
    .fwd_a_e    (c4_fwd_a_e),
    .fwd_b_e    (c4_fwd_b_e),
    .held_a     (c4_held_a),
    .held_b     (c4_held_b),
    .stall_cnt  (c4_stall_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    rs1_d = 0; rs2_d = 0; rs1_e = 0; rs2_e = 0; rd_e = 0; rd_w = 0;
    regwrite_e = 0; regwrite_w = 0; load_e = 0; pc_src_e = 0;
    mdu_start_e = 0; mdu_done = 0; result_w = 0;
  endtask

  // Advance past the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after an input change
  task automatic settle();
    #1;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    step();
    // Outputs during reset, with a W match and MDU start pending
    rs1_e = 5; rd_w = 5; regwrite_w = 1; mdu_start_e = 1;
    settle();
    check("rst_stall_f", stall_f, 0);
    check("rst_stall_e", stall_e, 0);
    check("rst_flush_dew", {flush_d, flush_e, flush_w}, 3'b111);
    check("rst_fwd_a", fwd_a_e, 2'b00);
    step();

    rst = 1'b0;
    idle();
    settle();
    check("run_idle_stalls", {stall_f, stall_d, stall_e}, 3'b000);
    check("run_idle_flushes", {flush_d, flush_e, flush_w}, 3'b000);
    check("reset_cnt", stall_cnt, 0);
    check("reset_held_a", held_a, 0);

    // Forwarding from W
    rs1_e = 5; rd_w = 5; regwrite_w = 1;
    settle();
    check("fwd_a_w", fwd_a_e, 2'b01);
    check("fwd_b_none", fwd_b_e, 2'b00);
    rs2_e = 5;
    settle();
    check("fwd_b_w", fwd_b_e, 2'b01);
    rd_w = 0;
    settle();
    check("fwd_a_rdw0", fwd_a_e, 2'b00);
    rd_w = 5; regwrite_w = 0;
    settle();
    check("fwd_a_nowrite", fwd_a_e, 2'b00);
    rs1_e = 0; rd_w = 0; regwrite_w = 1;
    settle();
    check("fwd_a_x0", fwd_a_e, 2'b00);
    idle();

    // x0 never creates load-use
    load_e = 1; rd_e = 0; regwrite_e = 1; rs1_d = 0;
    settle();
    check("lu_x0", stall_f, 0);

    // Load-use: exactly one bubble
    rd_e = 7; rs2_d = 7;
    settle();
    check("lu_stall_fd", {stall_f, stall_d}, 2'b11);
    check("lu_flush_e", flush_e, 1);
    check("lu_no_stall_e", {stall_e, flush_d}, 2'b00);
    step();
    idle();
    settle();
    check("lu_released", stall_f, 0);
    check("lu_cnt", stall_cnt, 1);

    // Branch overrides load-use
    load_e = 1; rd_e = 7; regwrite_e = 1; rs2_d = 7; pc_src_e = 1;
    settle();
    check("br_flush_de", {flush_d, flush_e}, 2'b11);
    check("br_no_stall", {stall_f, stall_d}, 2'b00);
    step();
    idle();
    settle();
    check("br_cnt", stall_cnt, 1);

    // MDU op with 4-cycle latency, operand A forwarded from W on entry
    mdu_start_e = 1; rs1_e = 3; rd_w = 3; regwrite_w = 1; result_w = 32'hDEAD_BEEF;
    settle();
    check("mdu0_stalls", {stall_f, stall_d, stall_e, flush_w}, 4'b1111);
    check("mdu0_fwd_a", fwd_a_e, 2'b01);
    step();
    rd_w = 0; regwrite_w = 0; result_w = 0;
    // Branch and load-use are ignored while waiting
    pc_src_e = 1; load_e = 1; rd_e = 7; regwrite_e = 1; rs1_d = 7;
    settle();
    check("mdu1_stalls", {stall_f, stall_d, stall_e, flush_w}, 4'b1111);
    check("mdu1_no_flush", {flush_d, flush_e}, 2'b00);
    check("mdu1_fwd_a", fwd_a_e, 2'b10);
    check("mdu1_fwd_b", fwd_b_e, 2'b00);
    check("mdu1_held_a", held_a, 32'hDEAD_BEEF);
    check("mdu1_held_b", held_b, 0);
    step();
    pc_src_e = 0; load_e = 0; regwrite_e = 0; rs1_d = 0; rd_e = 0;
    settle();
    check("mdu2_stall", stall_f, 1);
    step();
    mdu_done = 1;
    settle();
    check("mdu3_released", {stall_f, stall_d, stall_e, flush_w}, 4'b0000);
    check("mdu3_fwd_a", fwd_a_e, 2'b10);
    step();
    idle();
    rs1_e = 3;
    settle();
    check("mdu4_fwd_a", fwd_a_e, 2'b00);
    check("mdu4_run", stall_f, 0);
    check("mdu_cnt", stall_cnt, 4);

    // Reset in the 2nd MDU_WAIT cycle abandons the op
    idle();
    mdu_start_e = 1; rs2_e = 9; rd_w = 9; regwrite_w = 1; result_w = 32'h1234_5678;
    step();
    rd_w = 0; regwrite_w = 0; result_w = 0;
    settle();
    check("abort_fwd_b_held", fwd_b_e, 2'b10);
    check("abort_held_b", held_b, 32'h1234_5678);
    step();
    rst = 1;
    settle();
    check("abort_rst_stall", stall_f, 0);
    check("abort_rst_fwd_b", fwd_b_e, 2'b00);
    step();
    rst = 0;
    mdu_start_e = 0;
    settle();
    check("abort_run", stall_f, 0);
    check("abort_fwd_b", fwd_b_e, 2'b00);
    check("abort_held_b_clr", held_b, 0);
    check("abort_cnt", stall_cnt, 0);

    // 16-cycle MDU op gives 15 stall cycles, then one load-use wraps the 4-bit counter
    idle();
    mdu_start_e = 1;
    for (int i = 0; i < 15; i++) begin
      step();
    end
    mdu_done = 1;
    settle();
    check("wrap_done_release", stall_f, 0);
    check("wrap_cnt15", c4_stall_cnt, 15);
    step();
    idle();
    load_e = 1; rd_e = 4; regwrite_e = 1; rs1_d = 4;
    settle();
    check("wrap_lu_stall", c4_stall_f, 1);
    step();
    idle();
    settle();
    check("wrap_cnt0", c4_stall_cnt, 0);
    check("wide_cnt16", stall_cnt, 16);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
